// File: rtl/adc_pkg.sv
// Shared constants and state encoding for the dual-channel serial ADC reader.
// Imported by adc_sclk_gen and adc_reader.
package adc_pkg;

    localparam int SAMPLE_WIDTH = 12;
    localparam int FRAME_BITS   = 16;
    localparam int LEAD_ZEROS   = 4;
    localparam int CNT_WIDTH    = 8;

    localparam logic [4:0] FRAME_LAST = 5'(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        QUIET   = 2'd2
    } adcState_t;

    // A bit is shifted on the rise that follows fall number fallCnt.
    function automatic logic isLeadBit(logic [4:0] fallCnt);
        return fallCnt <= 5'(LEAD_ZEROS);
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial-clock divider: toggles outSerialClk every CLK_DIV enabled cycles and
// flags, one cycle ahead, the clock edge that is about to be driven.
module adc_sclk_gen
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic inClk,
    input  logic inReset,
    input  logic inEnable,
    output logic outSerialClk,
    output logic outRise,
    output logic outFall
);

    logic [CNT_WIDTH-1:0] divCnt;
    logic                 tick;

    assign tick    = inEnable && (divCnt == CNT_WIDTH'(CLK_DIV - 1));
    assign outRise = tick && !outSerialClk;
    assign outFall = tick && outSerialClk;

    always_ff @(posedge inClk) begin
        if (inReset || !inEnable) begin
            divCnt       <= '0;
            outSerialClk <= 1'b1;
        end else if (tick) begin
            divCnt       <= '0;
            outSerialClk <= ~outSerialClk;
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_reader.sv
// Dual-channel serial ADC reader: 16-bit frames, 4 leading zeros, 12 data bits.
// Define ADC_READER_ZERO_CHECK_EN to add the outFrameError leading-bit check.
module adc_reader
    import adc_pkg::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int QUIET_CYCLES = 4
) (
    input  logic                    inClk,
    input  logic                    inReset,
    input  logic                    inStart,
    input  logic                    inDataA,
    input  logic                    inDataB,
    output logic                    outChipSelect,
    output logic                    outSerialClk,
    output logic [SAMPLE_WIDTH-1:0] outSampleA,
    output logic [SAMPLE_WIDTH-1:0] outSampleB,
    output logic                    outSampleReady,
`ifdef ADC_READER_ZERO_CHECK_EN
    output logic                    outFrameError,
`endif
    output logic                    outBusy
);

    adcState_t               state;
    logic [4:0]              fallCnt;
    logic [CNT_WIDTH-1:0]    quietCnt;
    logic [SAMPLE_WIDTH-1:0] shiftA;
    logic [SAMPLE_WIDTH-1:0] shiftB;
    logic                    sclkRise;
    logic                    sclkFall;
    logic                    sclkEn;
    logic                    frameDone;
`ifdef ADC_READER_ZERO_CHECK_EN
    logic                    leadErr;
`endif

    // All 16 falls seen and the clock is back high: the 16th rise has happened.
    assign frameDone = (fallCnt == FRAME_LAST) && outSerialClk;
    assign sclkEn    = (state == CONVERT) && !frameDone;

    adc_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) sclkGen (
        .inClk       (inClk),
        .inReset     (inReset),
        .inEnable    (sclkEn),
        .outSerialClk(outSerialClk),
        .outRise     (sclkRise),
        .outFall     (sclkFall)
    );

    always_ff @(posedge inClk) begin
        if (inReset) begin
            state          <= IDLE;
            fallCnt        <= '0;
            quietCnt       <= '0;
            shiftA         <= '0;
            shiftB         <= '0;
            outChipSelect  <= 1'b1;
            outSampleA     <= '0;
            outSampleB     <= '0;
            outSampleReady <= 1'b0;
            outBusy        <= 1'b0;
`ifdef ADC_READER_ZERO_CHECK_EN
            leadErr        <= 1'b0;
            outFrameError  <= 1'b0;
`endif
        end else begin
            outSampleReady <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (inStart) begin
                        state         <= CONVERT;
                        outChipSelect <= 1'b0;
                        outBusy       <= 1'b1;
                        fallCnt       <= '0;
`ifdef ADC_READER_ZERO_CHECK_EN
                        leadErr       <= 1'b0;
`endif
                    end
                end
                CONVERT: begin
                    if (frameDone) begin
                        state          <= QUIET;
                        quietCnt       <= '0;
                        outChipSelect  <= 1'b1;
                        outSampleA     <= shiftA;
                        outSampleB     <= shiftB;
                        outSampleReady <= 1'b1;
`ifdef ADC_READER_ZERO_CHECK_EN
                        outFrameError  <= leadErr;
`endif
                    end else begin
                        if (sclkFall) begin
                            fallCnt <= fallCnt + 5'd1;
                        end
                        if (sclkRise) begin
                            shiftA <= {shiftA[SAMPLE_WIDTH-2:0], inDataA};
                            shiftB <= {shiftB[SAMPLE_WIDTH-2:0], inDataB};
`ifdef ADC_READER_ZERO_CHECK_EN
                            if (isLeadBit(fallCnt)) begin
                                leadErr <= leadErr | inDataA | inDataB;
                            end
`endif
                        end
                    end
                end
                QUIET: begin
                    if (quietCnt == CNT_WIDTH'(QUIET_CYCLES - 1)) begin
                        state   <= IDLE;
                        outBusy <= 1'b0;
                    end else begin
                        quietCnt <= quietCnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_reader.sv
// Bench for adc_reader: behavioural ADC models feed two instances
// (CLK_DIV=2 and CLK_DIV=1); a sample scoreboard checks every completed frame.
module tb_adc_reader;

    localparam int CLK_PERIOD = 10;
    localparam int CD0        = 2;
    localparam int QC0        = 4;
    localparam int CD1        = 1;

    logic inClk = 1'b0;
    logic inReset = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic dA0 = 1'b0, dB0 = 1'b0, dA1 = 1'b0, dB1 = 1'b0;

    logic        cs0, sclk0, rdy0, busy0;
    logic        cs1, sclk1, rdy1, busy1;
    logic [11:0] sA0, sB0, sA1, sB1;
`ifdef ADC_READER_ZERO_CHECK_EN
    logic        fe0, fe1;
`endif

    always #(CLK_PERIOD / 2) inClk = ~inClk;

    adc_reader #(.CLK_DIV(CD0), .QUIET_CYCLES(QC0)) dut0 (
        .inClk(inClk), .inReset(inReset), .inStart(start0),
        .inDataA(dA0), .inDataB(dB0),
        .outChipSelect(cs0), .outSerialClk(sclk0),
        .outSampleA(sA0), .outSampleB(sB0),
        .outSampleReady(rdy0),
`ifdef ADC_READER_ZERO_CHECK_EN
        .outFrameError(fe0),
`endif
        .outBusy(busy0)
    );

    adc_reader #(.CLK_DIV(CD1), .QUIET_CYCLES(QC0)) dut1 (
        .inClk(inClk), .inReset(inReset), .inStart(start1),
        .inDataA(dA1), .inDataB(dB1),
        .outChipSelect(cs1), .outSerialClk(sclk1),
        .outSampleA(sA1), .outSampleB(sB1),
        .outSampleReady(rdy1),
`ifdef ADC_READER_ZERO_CHECK_EN
        .outFrameError(fe1),
`endif
        .outBusy(busy1)
    );

    int nChecks = 0;
    int nFails = 0;

    typedef struct packed {
        logic [11:0] a;
        logic [11:0] b;
    } sample_t;
    sample_t sb[$];
    sample_t exp;

    // ADC models: present the next frame bit after each serial-clock fall.
    logic [15:0] wA0 = '0, wB0 = '0, wA1 = '0, wB1 = '0;
    int idx0 = 0, idx1 = 0;
    int rise0 = 0;
    time lastRise1 = 0, period1 = 0;

    always @(negedge cs0) idx0 = 0;
    always @(negedge cs1) idx1 = 0;

    always @(negedge sclk0) begin
        if (!cs0 && idx0 < 16) begin
            dA0 = wA0[15-idx0];
            dB0 = wB0[15-idx0];
            idx0++;
        end
    end

    always @(negedge sclk1) begin
        if (!cs1 && idx1 < 16) begin
            dA1 = wA1[15-idx1];
            dB1 = wB1[15-idx1];
            idx1++;
        end
    end

    always @(posedge sclk0) rise0++;

    always @(posedge sclk1) begin
        if (lastRise1 != 0) period1 = $time - lastRise1;
        lastRise1 = $time;
    end

    task automatic start0Pulse();
        @(negedge inClk);
        start0 = 1'b1;
        @(posedge inClk);
        #1;
        start0 = 1'b0;
    endtask

    task automatic start1Pulse();
        @(negedge inClk);
        start1 = 1'b1;
        @(posedge inClk);
        #1;
        start1 = 1'b0;
    endtask

    task automatic waitReady(input bit which, input int bound, output int cyc);
        cyc = -1;
        for (int k = 1; k <= bound; k++) begin
            @(posedge inClk);
            #1;
            if ((which ? rdy1 : rdy0) === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        inReset = 1'b1;
        repeat (2) @(posedge inClk);
        #1;
        nChecks++;
        if (cs0 !== 1'b1) begin
            nFails++; $display("FAIL reset_cs got %b want 1", cs0);
        end
        nChecks++;
        if (sclk0 !== 1'b1) begin
            nFails++; $display("FAIL reset_sclk got %b want 1", sclk0);
        end
        nChecks++;
        if (sA0 !== 12'h000 || sB0 !== 12'h000) begin
            nFails++; $display("FAIL reset_samples got %h/%h want 000/000", sA0, sB0);
        end
        nChecks++;
        if (rdy0 !== 1'b0 || busy0 !== 1'b0) begin
            nFails++; $display("FAIL reset_rdy_busy got %b%b want 00", rdy0, busy0);
        end
        nChecks++;
        if (cs1 !== 1'b1 || sclk1 !== 1'b1 || busy1 !== 1'b0) begin
            nFails++; $display("FAIL reset_dut1 got %b%b%b want 110", cs1, sclk1, busy1);
        end
`ifdef ADC_READER_ZERO_CHECK_EN
        nChecks++;
        if (fe0 !== 1'b0) begin
            nFails++; $display("FAIL reset_frame_error got %b want 0", fe0);
        end
`endif
        // start high in the same cycle as reset must be ignored
        start0 = 1'b1;
        @(posedge inClk);
        #1;
        start0 = 1'b0;
        nChecks++;
        if (busy0 !== 1'b0 || cs0 !== 1'b1) begin
            nFails++; $display("FAIL reset_priority got busy=%b cs=%b want 0 1", busy0, cs0);
        end
        @(negedge inClk);
        inReset = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        wA0 = {4'h0, 12'hABC};
        wB0 = {4'h0, 12'h123};
        sb.push_back({12'hABC, 12'h123});
        rise0 = 0;
        start0Pulse();
        nChecks++;
        if (busy0 !== 1'b1 || cs0 !== 1'b0 || sclk0 !== 1'b1) begin
            nFails++;
            $display("FAIL start_state got busy=%b cs=%b sclk=%b want 1 0 1", busy0, cs0, sclk0);
        end
        waitReady(1'b0, 200, cyc);
        nChecks++;
        if (cyc != 32 * CD0 + 1) begin
            nFails++; $display("FAIL basic_latency got %0d want %0d", cyc, 32 * CD0 + 1);
        end
        nChecks++;
        if (sb.size() == 0) begin
            nFails++; $display("FAIL basic_scoreboard got empty want entry");
        end else begin
            exp = sb.pop_front();
            if (sA0 !== exp.a || sB0 !== exp.b) begin
                nFails++;
                $display("FAIL basic_samples got %h/%h want %h/%h", sA0, sB0, exp.a, exp.b);
            end
        end
        nChecks++;
        if (rise0 != 16) begin
            nFails++; $display("FAIL basic_sclk_rises got %0d want 16", rise0);
        end
        nChecks++;
        if (cs0 !== 1'b1) begin
            nFails++; $display("FAIL basic_cs_at_ready got %b want 1", cs0);
        end
        @(posedge inClk);
        #1;
        nChecks++;
        if (rdy0 !== 1'b0) begin
            nFails++; $display("FAIL basic_pulse_width got %b want 0", rdy0);
        end
        repeat (20) @(posedge inClk);
        #1;
        nChecks++;
        if (sA0 !== 12'hABC || sB0 !== 12'h123 || busy0 !== 1'b0) begin
            nFails++;
            $display("FAIL basic_hold got %h/%h busy=%b want abc/123 0", sA0, sB0, busy0);
        end
`ifdef ADC_READER_ZERO_CHECK_EN
        nChecks++;
        if (fe0 !== 1'b0) begin
            nFails++; $display("FAIL basic_frame_error got %b want 0", fe0);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int cyc;
        int gap;
        int quiet;
        int extra;
        wA0 = {4'h0, 12'h5A5};
        wB0 = {4'h0, 12'h3C3};
        sb.push_back({12'h5A5, 12'h3C3});
        @(negedge inClk);
        start0 = 1'b1;
        @(posedge inClk);
        #1;
        waitReady(1'b0, 200, cyc);
        nChecks++;
        if (cyc != 32 * CD0 + 1) begin
            nFails++; $display("FAIL b2b_first_latency got %0d want %0d", cyc, 32 * CD0 + 1);
        end
        exp = sb.pop_front();
        nChecks++;
        if (sA0 !== exp.a || sB0 !== exp.b) begin
            nFails++; $display("FAIL b2b_first got %h/%h want %h/%h", sA0, sB0, exp.a, exp.b);
        end
        wA0 = {4'h0, 12'h0F0};
        wB0 = {4'h0, 12'hF0F};
        sb.push_back({12'h0F0, 12'hF0F});
        gap = -1;
        quiet = 0;
        for (int k = 1; k <= 200; k++) begin
            if (busy0 === 1'b1 && cs0 === 1'b1) quiet++;
            @(posedge inClk);
            #1;
            if (rdy0 === 1'b1) begin
                gap = k;
                break;
            end
        end
        start0 = 1'b0;
        nChecks++;
        if (gap != 32 * CD0 + QC0 + 2) begin
            nFails++; $display("FAIL b2b_period got %0d want %0d", gap, 32 * CD0 + QC0 + 2);
        end
        nChecks++;
        if (quiet != QC0) begin
            nFails++; $display("FAIL b2b_quiet_cycles got %0d want %0d", quiet, QC0);
        end
        exp = sb.pop_front();
        nChecks++;
        if (sA0 !== exp.a || sB0 !== exp.b) begin
            nFails++; $display("FAIL b2b_second got %h/%h want %h/%h", sA0, sB0, exp.a, exp.b);
        end
        extra = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge inClk);
            #1;
            if (rdy0 === 1'b1) extra++;
        end
        nChecks++;
        if (extra != 0 || busy0 !== 1'b0) begin
            nFails++; $display("FAIL b2b_stop got %0d pulses busy=%b want 0 0", extra, busy0);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int pulses;
        wA0 = {4'h0, 12'h777};
        wB0 = {4'h0, 12'h888};
        rise0 = 0;
        start0Pulse();
        for (int k = 0; k < 200; k++) begin
            @(posedge inClk);
            #1;
            if (rise0 >= 8) break;
        end
        nChecks++;
        if (rise0 != 8) begin
            nFails++; $display("FAIL mid_reach_rise8 got %0d want 8", rise0);
        end
        inReset = 1'b1;
        @(posedge inClk);
        #1;
        inReset = 1'b0;
        nChecks++;
        if (cs0 !== 1'b1 || sA0 !== 12'h000 || sB0 !== 12'h000) begin
            nFails++; $display("FAIL mid_reset_state got cs=%b %h/%h want 1 000/000", cs0, sA0, sB0);
        end
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge inClk);
            #1;
            if (rdy0 === 1'b1) pulses++;
        end
        nChecks++;
        if (pulses != 0 || busy0 !== 1'b0) begin
            nFails++; $display("FAIL mid_no_ready got %0d pulses busy=%b want 0 0", pulses, busy0);
        end
        wA0 = {4'h0, 12'h321};
        wB0 = {4'h0, 12'h654};
        sb.push_back({12'h321, 12'h654});
        start0Pulse();
        waitReady(1'b0, 200, cyc);
        nChecks++;
        if (cyc != 32 * CD0 + 1) begin
            nFails++; $display("FAIL mid_clean_latency got %0d want %0d", cyc, 32 * CD0 + 1);
        end
        exp = sb.pop_front();
        nChecks++;
        if (sA0 !== exp.a || sB0 !== exp.b) begin
            nFails++; $display("FAIL mid_clean_samples got %h/%h want %h/%h", sA0, sB0, exp.a, exp.b);
        end
        repeat (10) @(posedge inClk);
    endtask

    task automatic test_start_ignored();
        int pulses;
        int at;
        wA0 = {4'h0, 12'h9E1};
        wB0 = {4'h0, 12'h04D};
        sb.push_back({12'h9E1, 12'h04D});
        start0Pulse();
        pulses = 0;
        at = -1;
        for (int k = 1; k <= 200; k++) begin
            start0 = (k == 20 || k == 50);
            @(posedge inClk);
            #1;
            if (rdy0 === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    at = k;
                    exp = sb.pop_front();
                    nChecks++;
                    if (sA0 !== exp.a || sB0 !== exp.b) begin
                        nFails++;
                        $display("FAIL ignore_samples got %h/%h want %h/%h", sA0, sB0, exp.a, exp.b);
                    end
                end
            end
        end
        start0 = 1'b0;
        nChecks++;
        if (pulses != 1 || at != 32 * CD0 + 1) begin
            nFails++; $display("FAIL ignore_pulses got %0d at %0d want 1 at %0d", pulses, at, 32 * CD0 + 1);
        end
    endtask

    task automatic test_clkdiv1();
        int cyc;
        wA1 = {4'h0, 12'hFFF};
        wB1 = {4'h0, 12'h000};
        sb.push_back({12'hFFF, 12'h000});
        start1Pulse();
        waitReady(1'b1, 100, cyc);
        nChecks++;
        if (cyc != 32 * CD1 + 1) begin
            nFails++; $display("FAIL div1_latency got %0d want %0d", cyc, 32 * CD1 + 1);
        end
        exp = sb.pop_front();
        nChecks++;
        if (sA1 !== exp.a || sB1 !== exp.b) begin
            nFails++; $display("FAIL div1_samples got %h/%h want %h/%h", sA1, sB1, exp.a, exp.b);
        end
        nChecks++;
        if (period1 != 2 * CLK_PERIOD) begin
            nFails++; $display("FAIL div1_sclk_period got %0t want %0d", period1, 2 * CLK_PERIOD);
        end
        repeat (10) @(posedge inClk);
    endtask

`ifdef ADC_READER_ZERO_CHECK_EN
    task automatic test_zero_check();
        int cyc;
        wA0 = {4'h0, 12'hABC};
        wB0 = {4'b0100, 12'h123};
        sb.push_back({12'hABC, 12'h123});
        start0Pulse();
        waitReady(1'b0, 200, cyc);
        exp = sb.pop_front();
        nChecks++;
        if (cyc != 32 * CD0 + 1 || fe0 !== 1'b1) begin
            nFails++; $display("FAIL zc_error got cyc=%0d fe=%b want %0d 1", cyc, fe0, 32 * CD0 + 1);
        end
        nChecks++;
        if (sA0 !== exp.a || sB0 !== exp.b) begin
            nFails++; $display("FAIL zc_samples got %h/%h want %h/%h", sA0, sB0, exp.a, exp.b);
        end
        repeat (20) @(posedge inClk);
        #1;
        nChecks++;
        if (fe0 !== 1'b1) begin
            nFails++; $display("FAIL zc_hold got %b want 1", fe0);
        end
        wB0 = {4'h0, 12'h123};
        sb.push_back({12'hABC, 12'h123});
        start0Pulse();
        waitReady(1'b0, 200, cyc);
        exp = sb.pop_front();
        nChecks++;
        if (cyc != 32 * CD0 + 1 || fe0 !== 1'b0) begin
            nFails++; $display("FAIL zc_clear got cyc=%0d fe=%b want %0d 0", cyc, fe0, 32 * CD0 + 1);
        end
        repeat (10) @(posedge inClk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid();
        test_start_ignored();
        test_clkdiv1();
`ifdef ADC_READER_ZERO_CHECK_EN
        test_zero_check();
`endif
        nChecks++;
        if (sb.size() != 0) begin
            nFails++; $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
